// File: rtl/tetris_mode_ctrl_pkg.sv
// Shared screen/mode constants for the Tetris mode sequencer, VGA screen mux and game engine.
// Holds the 2-bit state codes, the one-hot mode bit indices and the state enum.
package tetris_mode_ctrl_pkg;

    localparam logic [1:0] MODE_HOME  = 2'b00;
    localparam logic [1:0] MODE_GAME  = 2'b01;
    localparam logic [1:0] MODE_PAUSE = 2'b10;
    localparam logic [1:0] MODE_END   = 2'b11;

    localparam int BIT_HOME  = 0;
    localparam int BIT_GAME  = 1;
    localparam int BIT_PAUSE = 2;
    localparam int BIT_END   = 3;

    typedef enum logic [1:0] {
        ST_HOME  = MODE_HOME,
        ST_GAME  = MODE_GAME,
        ST_PAUSE = MODE_PAUSE,
        ST_END   = MODE_END
    } state_t;

    function automatic logic [3:0] mode_onehot(input state_t s);
        logic [3:0] m;
        m = '0;
        unique case (s)
            ST_HOME:  m[BIT_HOME]  = 1'b1;
            ST_GAME:  m[BIT_GAME]  = 1'b1;
            ST_PAUSE: m[BIT_PAUSE] = 1'b1;
            ST_END:   m[BIT_END]   = 1'b1;
            default:  m[BIT_HOME]  = 1'b1;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/tetris_mode_ctrl_rise_detect.sv
// rise_detect: 1-bit registered rising-edge detector whose history resets to 1,
// so a level held through reset only fires after release and re-press.
// Ports: Clk, Resetn (sync, active-low), d (level in), rise (combinational pulse).
module rise_detect (
    input  logic Clk,
    input  logic Resetn,
    input  logic d,
    output logic rise
);

    logic q;

    always_ff @(posedge Clk) begin
        if (!Resetn) q <= 1'b1;
        else         q <= d;
    end

    assign rise = d & ~q;

endmodule

// File: rtl/tetris_mode_ctrl.sv
// tetris_mode_ctrl: Home/Game/Pause/End screen sequencer with restart, timed auto-return
// from End, edge-qualified buttons and a one-cycle board-clear pulse on each new game.
// Ports: Clk, Resetn (sync, active-low), start, pause_btn, gameover, tick (inputs);
//        mode (one-hot {End,Pause,Game,Home}), state (2-bit code), game_clear (outputs).
module tetris_mode_ctrl
    import tetris_mode_ctrl_pkg::*;
#(
    parameter int END_TIMEOUT = 300,
    parameter int CNT_W       = 9,
    parameter bit AUTO_RETURN = 1'b1
) (
    input  logic       Clk,
    input  logic       Resetn,
    input  logic       start,
    input  logic       pause_btn,
    input  logic       gameover,
    input  logic       tick,
    output logic [3:0] mode,
    output logic [1:0] state,
    output logic       game_clear
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(END_TIMEOUT - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             clr_q, clr_d;
    logic             start_rise, pause_rise;

    rise_detect u_start_rd (
        .Clk    (Clk),
        .Resetn (Resetn),
        .d      (start),
        .rise   (start_rise)
    );

    rise_detect u_pause_rd (
        .Clk    (Clk),
        .Resetn (Resetn),
        .d      (pause_btn),
        .rise   (pause_rise)
    );

    always_ff @(posedge Clk) begin
        if (!Resetn) begin
            state_q <= ST_HOME;
            cnt_q   <= '0;
            clr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            clr_q   <= clr_d;
        end
    end

    // Counter only lives in End; every other state forces it to 0,
    // so any entry to End starts from 0.
    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        clr_d   = 1'b0;
        unique case (state_q)
            ST_HOME: begin
                if (start_rise) begin
                    state_d = ST_GAME;
                    clr_d   = 1'b1;
                end
            end
            ST_GAME: begin
                if (gameover)        state_d = ST_END;
                else if (pause_rise) state_d = ST_PAUSE;
            end
            ST_PAUSE: begin
                if (pause_rise || start_rise) state_d = ST_GAME;
            end
            ST_END: begin
                cnt_d = cnt_q;
                if (start_rise) begin
                    state_d = ST_GAME;
                    clr_d   = 1'b1;
                    cnt_d   = '0;
                end else if (tick) begin
                    if (cnt_q == CNT_LAST) begin
                        if (AUTO_RETURN) begin
                            state_d = ST_HOME;
                            cnt_d   = '0;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_HOME;
            end
        endcase
    end

    assign mode       = mode_onehot(state_q);
    assign state      = state_q;
    assign game_clear = clr_q;

endmodule
